// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Single-port data memory that answers processor load/store requests after a
// fixed number of wait cycles. An access is captured in IDLE, held in BUSY for
// WAIT_CYCLES cycles, and answered with a one-cycle response strobe in DONE.
//
// Parameters
//   DEPTH_LOG2   log2 of the number of 32-bit words held in the array
//   WAIT_CYCLES  number of BUSY cycles per access (0..15)
//
// Ports
//   clock      rising-edge clock for all state
//   reset      synchronous, active-high; clears the FSM and the response and
//              latched-request registers but never the memory array
//   req_read   load request
//   req_write  store request
//   req_addr   byte address of the access
//   req_wdata  store data
//   stall      combinational pipeline hold: (IDLE & request) | BUSY
//   rd_data    load data, non-zero only in the response cycle
//   rd_valid   one-cycle response strobe for both loads and stores
//   err        access fault (misaligned, out of range, or read+write at once),
//              qualified by rd_valid
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        err
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  // BUSY is entered with WAIT_CYCLES-1 so that cnt==0 marks the last BUSY cycle.
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  // With zero wait cycles an access goes straight from IDLE to DONE.
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      state_reg;
  logic [3:0]  cnt_reg;

  // Request captured in IDLE; held unchanged until the next capture.
  logic        rd_op_reg;
  logic        wr_op_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;

  // Response registers: only non-zero during the DONE cycle.
  logic        rd_valid_reg;
  logic        err_reg;
  logic [31:0] rd_data_reg;

  // Memory array; never reset.
  logic [31:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Combinational access view
  // ---------------------------------------------------------------------------
  logic                  req_present;
  logic                  acc_rd;
  logic                  acc_wr;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  acc_misaligned;
  logic                  acc_out_of_range;
  logic                  acc_conflict;
  logic                  acc_err;
  logic                  acc_fire;
  logic                  mem_we;

  assign req_present = req_read | req_write;

  // The access that completes at the coming edge is normally the latched one.
  // Only with zero wait cycles does the live request complete at its own
  // capture edge, so in IDLE the view looks straight at the inputs.
  always_comb begin
    if (state_reg == IDLE) begin
      acc_rd    = req_read;
      acc_wr    = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_rd    = rd_op_reg;
      acc_wr    = wr_op_reg;
      acc_addr  = addr_reg;
      acc_wdata = wdata_reg;
    end

    acc_idx          = acc_addr[DEPTH_LOG2+1:2];
    acc_misaligned   = (acc_addr[1:0] != 2'b00);
    acc_out_of_range = (acc_addr[31:DEPTH_LOG2+2] != '0);
    acc_conflict     = acc_rd & acc_wr;
    acc_err          = acc_misaligned | acc_out_of_range | acc_conflict;

    // acc_fire is high in the cycle whose closing edge enters DONE.
    acc_fire = ((state_reg == IDLE) && req_present && NO_WAIT) ||
               ((state_reg == BUSY) && (cnt_reg == 4'd0));

    // Reset on the same edge cancels a store that has not yet committed.
    mem_we = acc_fire & acc_wr & ~acc_err & ~reset;
  end

  // ---------------------------------------------------------------------------
  // Memory write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM, request capture and registered response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      rd_op_reg    <= 1'b0;
      wr_op_reg    <= 1'b0;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
      rd_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
      rd_data_reg  <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_present) begin
            rd_op_reg <= req_read;
            wr_op_reg <= req_write;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            if (NO_WAIT) begin
              state_reg <= DONE;
            end else begin
              state_reg <= BUSY;
              cnt_reg   <= CNT_INIT;
            end
          end
        end

        BUSY: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end

        // A request seen during DONE is left for the following IDLE cycle.
        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase

      // Registered read: the array is sampled on the edge that enters DONE.
      // A read and a write of the same word can only meet within one access,
      // and that combination is always a fault, so read-first ordering is safe.
      if (acc_fire) begin
        rd_valid_reg <= 1'b1;
        err_reg      <= acc_err;
        rd_data_reg  <= (acc_rd && !acc_err) ? mem[acc_idx] : 32'd0;
      end else begin
        rd_valid_reg <= 1'b0;
        err_reg      <= 1'b0;
        rd_data_reg  <= 32'd0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign stall    = ((state_reg == IDLE) && req_present) || (state_reg == BUSY);
  assign rd_valid = rd_valid_reg;
  assign err      = err_reg;
  assign rd_data  = rd_data_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Two responders share one clock and reset: instance 0 with DEPTH_LOG2=8 and
// WAIT_CYCLES=2, instance 1 with DEPTH_LOG2=4 and WAIT_CYCLES=0. A word-array
// reference model per instance predicts fault, data and timing of each access
// from the address arithmetic alone.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int DL_A = 8;
  localparam int W_A  = 2;
  localparam int DL_B = 4;
  localparam int W_B  = 0;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_read  [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        stall     [2];
  logic [31:0] rd_data   [2];
  logic        rd_valid  [2];
  logic        err       [2];

  logic [31:0] model_a [2**DL_A];
  logic [31:0] model_b [2**DL_B];

  int check_count = 0;
  int error_count = 0;
  int txn_count   = 0;

  always #5 clock = ~clock;

  dmem_responder #(.DEPTH_LOG2(DL_A), .WAIT_CYCLES(W_A)) u_dut_a (
    .clock    (clock),
    .reset    (reset),
    .req_read (req_read[0]),
    .req_write(req_write[0]),
    .req_addr (req_addr[0]),
    .req_wdata(req_wdata[0]),
    .stall    (stall[0]),
    .rd_data  (rd_data[0]),
    .rd_valid (rd_valid[0]),
    .err      (err[0])
  );

  dmem_responder #(.DEPTH_LOG2(DL_B), .WAIT_CYCLES(W_B)) u_dut_b (
    .clock    (clock),
    .reset    (reset),
    .req_read (req_read[1]),
    .req_write(req_write[1]),
    .req_addr (req_addr[1]),
    .req_wdata(req_wdata[1]),
    .stall    (stall[1]),
    .rd_data  (rd_data[1]),
    .rd_valid (rd_valid[1]),
    .err      (err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int depth_log(input int inst);
    return (inst == 0) ? DL_A : DL_B;
  endfunction

  function automatic int wait_of(input int inst);
    return (inst == 0) ? W_A : W_B;
  endfunction

  // Fault rule: byte address must be word aligned, the word number must lie
  // inside the array, and a request may not be both load and store.
  function automatic bit fault_of(input int inst, input bit rd, input bit wr, input logic [31:0] addr);
    longint unsigned words;
    words = longint'(1) << depth_log(inst);
    return ((addr % 4) != 0) || ((longint'(addr) / 4) >= words) || (rd && wr);
  endfunction

  function automatic logic [31:0] model_read(input int inst, input int idx);
    return (inst == 0) ? model_a[idx] : model_b[idx];
  endfunction

  task automatic model_write(input int inst, input int idx, input logic [31:0] d);
    if (inst == 0) model_a[idx] = d;
    else           model_b[idx] = d;
  endtask

  task automatic drive_idle(input int inst);
    req_read[inst]  = 1'b0;
    req_write[inst] = 1'b0;
    req_addr[inst]  = 32'd0;
    req_wdata[inst] = 32'd0;
  endtask

  // One complete access. Called and returns at posedge+1.
  task automatic access(input int inst, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit scramble);
    bit          exp_err;
    logic [31:0] exp_data;
    int          idx;
    int          cyc;
    int          stall_cnt;
    bit          seen;

    exp_err  = fault_of(inst, rd, wr, addr);
    idx      = int'(addr / 4) % (1 << depth_log(inst));
    exp_data = 32'd0;
    if (!exp_err && rd) exp_data = model_read(inst, idx);

    req_read[inst]  = rd;
    req_write[inst] = wr;
    req_addr[inst]  = addr;
    req_wdata[inst] = wdata;

    #1;
    stall_cnt = stall[inst] ? 1 : 0;
    chk("valid_at_request", 32'(rd_valid[inst]), 32'd0);

    cyc  = 0;
    seen = 1'b0;
    while (cyc < 40 && !seen) begin
      @(posedge clock);
      #1;
      cyc++;
      if (rd_valid[inst]) begin
        seen = 1'b1;
      end else begin
        if (stall[inst]) stall_cnt++;
        // Captured request must be immune to input changes.
        if (scramble) begin
          req_read[inst]  = 1'($urandom);
          req_write[inst] = 1'($urandom);
          req_addr[inst]  = $urandom;
          req_wdata[inst] = $urandom;
        end
      end
    end

    chk("resp_seen", 32'(seen), 32'd1);
    chk("latency", 32'(cyc), 32'(wait_of(inst) + 1));
    chk("stall_cycles", 32'(stall_cnt), 32'(wait_of(inst) + 1));
    chk("stall_in_done", 32'(stall[inst]), 32'd0);
    chk("err", 32'(err[inst]), 32'(exp_err));
    chk("rd_data", rd_data[inst], exp_data);

    txn_count++;
    $display("txn %0d inst=%0d rd=%0b wr=%0b addr=%h wdata=%h -> err=%0b rd_data=%h",
             txn_count, inst, rd, wr, addr, wdata, err[inst], rd_data[inst]);

    if (!exp_err && wr) model_write(inst, idx, wdata);

    drive_idle(inst);
    @(posedge clock);
    #1;
    chk("valid_after_done", 32'(rd_valid[inst]), 32'd0);
    chk("stall_idle", 32'(stall[inst]), 32'd0);
  endtask

  task automatic random_access(input int inst, input bit scramble);
    int          sel;
    int          op;
    int          words;
    logic [31:0] addr;
    bit          rd;
    bit          wr;
    words = 1 << depth_log(inst);
    sel   = int'($urandom_range(0, 9));
    if (sel == 0)      addr = ($urandom_range(0, words - 1) << 2) | 32'($urandom_range(1, 3));
    else if (sel == 1) addr = 32'(words * 4) + ($urandom_range(0, 255) << 2);
    else               addr = $urandom_range(0, words - 1) << 2;
    op = int'($urandom_range(0, 9));
    rd = (op == 0) || (op < 5);
    wr = (op == 0) || (op >= 5);
    access(inst, rd, wr, addr, $urandom, scramble);
  endtask

  initial begin
    reset = 1'b1;
    drive_idle(0);
    drive_idle(1);
    repeat (3) @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_rd_valid", 32'(rd_valid[i]), 32'd0);
      chk("reset_err", 32'(err[i]), 32'd0);
      chk("reset_rd_data", rd_data[i], 32'd0);
      chk("reset_stall", 32'(stall[i]), 32'd0);
    end
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Fill both arrays so every later load has a known answer.
    for (int w = 0; w < (1 << DL_A); w++) access(0, 1'b0, 1'b1, 32'(w * 4), $urandom, 1'b0);
    for (int w = 0; w < (1 << DL_B); w++) access(1, 1'b0, 1'b1, 32'(w * 4), $urandom, 1'b0);

    // Store then load, misaligned load, out-of-range store, conflicting op.
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    access(0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    access(0, 1'b0, 1'b1, 32'h400, 32'h11111111, 1'b0);
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    access(0, 1'b1, 1'b1, 32'h8, 32'hCAFEF00D, 1'b0);
    access(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);

    // Reset in the first BUSY cycle of a store cancels it.
    access(0, 1'b0, 1'b1, 32'h20, 32'hAAAA0000, 1'b0);
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h20;
    req_wdata[0] = 32'h12345678;
    @(posedge clock);
    #1;
    chk("busy_stall", 32'(stall[0]), 32'd1);
    reset = 1'b1;
    drive_idle(0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_rd_valid", 32'(rd_valid[0]), 32'd0);
    chk("rst_stall", 32'(stall[0]), 32'd0);
    chk("rst_err", 32'(err[0]), 32'd0);
    chk("rst_rd_data", rd_data[0], 32'd0);
    repeat (4) begin
      @(posedge clock);
      #1;
      chk("rst_no_late_resp", 32'(rd_valid[0]), 32'd0);
    end
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

    // Randomized traffic on the waiting instance, with input scrambling.
    for (int n = 0; n < 150; n++) random_access(0, n[0]);

    // Zero-wait instance: a load held continuously; the address moves on in
    // each DONE cycle and is only picked up in the IDLE cycle after it.
    req_read[1] = 1'b1;
    req_addr[1] = 32'h0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("b2b_stall", 32'(stall[1]), 32'((k % 2) == 0));
      chk("b2b_valid", 32'(rd_valid[1]), 32'((k % 2) == 1));
      if ((k % 2) == 1) begin
        chk("b2b_data", rd_data[1], model_b[k / 2]);
        chk("b2b_err", 32'(err[1]), 32'd0);
        $display("txn %0d inst=1 back-to-back read addr=%h -> rd_data=%h",
                 ++txn_count, 32'((k / 2) * 4), rd_data[1]);
        req_addr[1] = 32'(((k / 2) + 1) * 4);
      end
      @(posedge clock);
    end
    #1;
    drive_idle(1);
    @(posedge clock);
    #1;

    for (int n = 0; n < 60; n++) random_access(1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
